// File: rtl/multicycle_control_unit_if.sv
// multicycle_control_unit_if
// Bundle between the multicycle control unit and its datapath/memory environment.
//   Datapath -> control : cond, op, funct, link (instruction fields), ALUFlags,
//                         mem_ready (memory completes the current access).
//   Control -> datapath : NZCV flag register, PCWrite/IRWrite/RegWrite/MemWrite/
//                         MemRead enables, AdrSrc, ALUSrcB, ResultSrc, ImmSrc,
//                         RegSrc, ALUOp, debug state and sticky fault.
// master modport: the control unit. slave modport: the datapath side.
interface multicycle_control_unit_if;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic       link;
    logic [3:0] ALUFlags;
    logic       mem_ready;

    logic [3:0] NZCV;
    logic       PCWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic       MemWrite;
    logic       MemRead;
    logic       AdrSrc;
    logic       ALUSrcB;
    logic [1:0] ResultSrc;
    logic [1:0] ImmSrc;
    logic [1:0] RegSrc;
    logic [3:0] ALUOp;
    logic [3:0] state;
    logic       fault;

    modport master (
        input  cond, op, funct, link, ALUFlags, mem_ready,
        output NZCV, PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
               AdrSrc, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUOp, state, fault
    );

    modport slave (
        output cond, op, funct, link, ALUFlags, mem_ready,
        input  NZCV, PCWrite, IRWrite, RegWrite, MemWrite, MemRead,
               AdrSrc, ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUOp, state, fault
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
// Multicycle ARM-style control FSM: fetch, decode with condition evaluation,
// data-processing, load/store and branch sequences, with a memory wait timeout
// that parks the block in a sticky FAULT state until reset.
// Ports:
//   clk    - single rising-edge clock
//   reset  - synchronous, active-high
//   bus    - multicycle_control_unit_if.master (instruction fields, ALU flags,
//            mem_ready in; datapath enables, NZCV, state and fault out)
module multicycle_control_unit #(
    parameter int         MEM_TIMEOUT = 16,
    parameter logic [3:0] CMP_OP      = 4'b1010,
    parameter bit         ENABLE_BL   = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        EXEC   = 4'd2,
        ALUWB  = 4'd3,
        MEMADR = 4'd4,
        MEMRD  = 4'd5,
        MEMWB  = 4'd6,
        MEMWR  = 4'd7,
        BRANCH = 4'd8,
        FAULT  = 4'd9
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_q;
    state_t     state_d;
    state_t     out_state;
    logic [3:0] nzcv_q;
    logic [7:0] wait_cnt;
    logic       cond_pass;
    logic       waiting;
    logic       timed_out;

    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       adr_src;
    logic       alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [3:0] alu_op;

    // Condition check against the architectural flags (not this cycle's ALU flags).
    always_comb begin
        logic n, z, c, v;
        {n, z, c, v} = nzcv_q;
        cond_pass = 1'b0;
        case (bus.cond)
            4'b0000: cond_pass = z;
            4'b0001: cond_pass = ~z;
            4'b0010: cond_pass = c;
            4'b0011: cond_pass = ~c;
            4'b0100: cond_pass = n;
            4'b0101: cond_pass = ~n;
            4'b0110: cond_pass = v;
            4'b0111: cond_pass = ~v;
            4'b1000: cond_pass = c & ~z;
            4'b1001: cond_pass = ~c | z;
            4'b1010: cond_pass = (n == v);
            4'b1011: cond_pass = (n != v);
            4'b1100: cond_pass = ~z & (n == v);
            4'b1101: cond_pass = z | (n != v);
            4'b1110: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

    // Timeout fires on the last allowed stall cycle only if memory is still not
    // ready, so a completion on the threshold cycle is honoured.
    assign waiting   = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timed_out = waiting && !bus.mem_ready && (wait_cnt == TIMEOUT_LAST);

    // State register, flag register and wait counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            nzcv_q   <= 4'b0000;
            wait_cnt <= 8'd0;
        end else begin
            state_q <= state_d;
            if (state_d != state_q) begin
                wait_cnt <= 8'd0;
            end else if (waiting && !bus.mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state_q == EXEC && bus.funct[0]) begin
                nzcv_q <= bus.ALUFlags;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (bus.mem_ready) state_d = DECODE;
                else if (timed_out) state_d = FAULT;
            end
            DECODE: begin
                if (!cond_pass) begin
                    state_d = FETCH;
                end else begin
                    case (bus.op)
                        2'b00:   state_d = EXEC;
                        2'b01:   state_d = MEMADR;
                        2'b10:   state_d = BRANCH;
                        default: state_d = FAULT;
                    endcase
                end
            end
            EXEC:   state_d = (bus.funct[4:1] == CMP_OP) ? FETCH : ALUWB;
            ALUWB:  state_d = FETCH;
            MEMADR: state_d = bus.funct[0] ? MEMRD : MEMWR;
            MEMRD: begin
                if (bus.mem_ready) state_d = MEMWB;
                else if (timed_out) state_d = FAULT;
            end
            MEMWB:  state_d = FETCH;
            MEMWR: begin
                if (bus.mem_ready) state_d = FETCH;
                else if (timed_out) state_d = FAULT;
            end
            BRANCH: state_d = FETCH;
            FAULT:  state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    // While reset is held the outputs already look like an idle FETCH, so any
    // in-flight store is dropped immediately rather than at the clock edge.
    assign out_state = reset ? FETCH : state_q;

    // Output decode.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        adr_src    = 1'b0;
        alu_src_b  = 1'b0;
        result_src = 2'b00;
        imm_src    = 2'b00;
        reg_src    = 2'b00;
        alu_op     = 4'b0100;
        case (out_state)
            FETCH: begin
                mem_read = 1'b1;
                if (bus.mem_ready && !reset) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                end
            end
            EXEC: begin
                alu_op    = bus.funct[4:1];
                alu_src_b = bus.funct[5];
            end
            ALUWB: begin
                reg_write = 1'b1;
            end
            MEMADR: begin
                imm_src   = 2'b01;
                alu_src_b = ~bus.funct[5];
                alu_op    = bus.funct[3] ? 4'b0100 : 4'b0010;
            end
            MEMRD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                result_src = 2'b01;
            end
            MEMWR: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            BRANCH: begin
                imm_src    = 2'b10;
                reg_src    = 2'b01;
                alu_src_b  = 1'b1;
                pc_write   = 1'b1;
                result_src = 2'b10;
                reg_write  = ENABLE_BL & bus.link;
            end
            default: begin
            end
        endcase
    end

    assign bus.NZCV      = nzcv_q;
    assign bus.PCWrite   = pc_write;
    assign bus.IRWrite   = ir_write;
    assign bus.RegWrite  = reg_write;
    assign bus.MemWrite  = mem_write;
    assign bus.MemRead   = mem_read;
    assign bus.AdrSrc    = adr_src;
    assign bus.ALUSrcB   = alu_src_b;
    assign bus.ResultSrc = result_src;
    assign bus.ImmSrc    = imm_src;
    assign bus.RegSrc    = reg_src;
    assign bus.ALUOp     = alu_op;
    assign bus.state     = state_q;
    assign bus.fault     = (state_q == FAULT);

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum consecutive cycles waiting for mem_ready before the block faults (range 2..255).
REQ-002 Parameter CMP_OP, default 4'b1010: ALUOp code that updates flags with no register write.
REQ-003 Parameter ENABLE_BL, default 1: when 1, a branch with link=1 writes R14.
REQ-004 Clocking is decided: one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  single clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 cond/op/funct  in  4/2/6  instruction fields [31:28]/[27:26]/[25:20], valid from the DECODE state onward.
REQ-008 link  in  1  instruction bit 24 (BL).
REQ-009 ALUFlags  in  4  NZCV produced by the ALU in the current cycle.
REQ-010 mem_ready  in  1  memory completes the current access this cycle.
REQ-011 NZCV  out  4  architectural flag register.
REQ-012 PCWrite, IRWrite, RegWrite, MemWrite, MemRead  out  1 each  datapath enables.
REQ-013 AdrSrc  out  1  memory address select: 0 = PC, 1 = ALU result.
REQ-014 ALUSrcB  out  1  ALU operand B select: 0 = register, 1 = immediate.
REQ-015 ResultSrc  out  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+4.
REQ-016 ImmSrc, RegSrc  out  2 each  same encodings as the single-cycle unit.
REQ-017 ALUOp  out  4  ALU operation code.
REQ-018 state  out  4  current FSM state, for debug.
REQ-019 fault  out  1  sticky error indication.

Function
REQ-020 States and encodings: FETCH=0, DECODE=1, EXEC=2, ALUWB=3, MEMADR=4, MEMRD=5, MEMWB=6, MEMWR=7, BRANCH=8, FAULT=9.
REQ-021 Every output not explicitly driven in a state SHALL be 0; ALUOp default is 4'b0100 (add).
REQ-022 FETCH: MemRead=1, AdrSrc=0; while mem_ready=0, hold FETCH.
REQ-023 FETCH with mem_ready=1: pulse IRWrite=1 and PCWrite=1 (PC+4) for one cycle, then move to DECODE.
REQ-024 DECODE: evaluate cond against the registered NZCV for all 16 codes (EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL; 1111 = never).
REQ-025 DECODE, cond false: go to FETCH with no side effects.
REQ-026 DECODE, cond true: op=00 -> EXEC, op=01 -> MEMADR, op=10 -> BRANCH, op=11 -> FAULT.
REQ-027 EXEC: ALUOp=funct[4:1], ALUSrcB=funct[5], ImmSrc=00.
REQ-028 EXEC flag update: if funct[0]=1, latch NZCV<=ALUFlags at the end of the cycle.
REQ-029 EXEC exit: next state FETCH if funct[4:1]==CMP_OP, else ALUWB.
REQ-030 ALUWB: RegWrite=1, ResultSrc=00, then FETCH.
REQ-031 MEMADR: ImmSrc=01, ALUSrcB=~funct[5], ALUOp = funct[3] ? 4'b0100 : 4'b0010.
REQ-032 MEMADR exit: next state MEMRD if funct[0]=1, else MEMWR; NZCV is never modified on this path.
REQ-033 MEMRD: MemRead=1, AdrSrc=1; hold until mem_ready=1, then MEMWB.
REQ-034 MEMWB: RegWrite=1, ResultSrc=01, then FETCH.
REQ-035 MEMWR: MemWrite=1, AdrSrc=1, held continuously until mem_ready=1, then FETCH.
REQ-036 BRANCH: ImmSrc=10, RegSrc=01, ALUSrcB=1, ALUOp=0100, PCWrite=1.
REQ-037 BRANCH link write: RegWrite = ENABLE_BL & link, with ResultSrc=10; then FETCH, one cycle total.
REQ-038 Wait counter, 8-bit: increments each cycle spent in FETCH, MEMRD or MEMWR with mem_ready=0, and clears on every state change.
REQ-039 Wait counter == MEM_TIMEOUT-1 with mem_ready still 0: next state FAULT and no further enables are issued.
REQ-040 FAULT: all enables 0, fault=1; state held until reset.
REQ-041 Simultaneous mem_ready=1 and timeout threshold: mem_ready wins and the access completes normally.

Reset
REQ-042 With reset=1 at a rising clk edge: state<=FETCH, NZCV<=0000, wait counter<=0, fault<=0; applies mid-access, including from FAULT.
REQ-043 Outputs during and immediately after reset are the FETCH-state values; a pending MemWrite is dropped.

Verification
REQ-044 Data-processing instruction, mem_ready tied 1: ADDS (funct=101001) with ALUFlags=0100 -> FETCH, DECODE, EXEC, ALUWB in 4 cycles; NZCV=0100; RegWrite for exactly 1 cycle.
REQ-045 Conditional skip: CMP (funct=010101) sets Z; then BNE (cond=0001) -> DECODE returns to FETCH, PCWrite only in FETCH; BEQ -> BRANCH cycle with PCWrite=1.
REQ-046 Load with stall: LDR with mem_ready low 3 cycles in MEMRD -> MemRead held 4 cycles, then MEMWB with ResultSrc=01 and RegWrite=1.
REQ-047 Timeout: STR with MEM_TIMEOUT=4 and mem_ready held 0 -> MemWrite high 4 cycles, then state=9 and fault=1; reset -> state=0 and fault=0.
REQ-048 Branch with link: BL (link=1), ENABLE_BL=1 -> RegWrite=1, ResultSrc=10; with ENABLE_BL=0 -> RegWrite=0.
REQ-049 Full condition table: sweep all 16 cond codes against all 16 NZCV values and compare the DECODE exit state against a reference table (256 cases).
